multicycle_control: RTL

- Registered, multi-cycle successor to the combinational opcode-to-control decoder of the RV32I core.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and latches the 11-bit control word once per instruction.
- Gates write/read strobes to the correct phase, handles memory wait states with a ready handshake and a parametrised timeout, and traps illegal opcodes into a sticky FAULT state.
- Sits between the instruction register/datapath and the unified memory port.

---
 rtl/multicycle_control_if.sv | 31 +++
 rtl/multicycle_control.sv | 112 +++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle for the multi-cycle RV32I control unit.
// master = the controller, slave = the datapath/memory side.
interface multicycle_control_if;
  logic [6:0]  opcode_w_i;
  logic        mem_ready_w_i_h;
  logic [10:0] ctrl_w_o;
  logic [2:0]  state_w_o;
  logic        mem_req_w_o_h;
  logic        instr_sel_w_o_h;
  logic        ir_write_w_o_h;
  logic        mem_wr_w_o_h;
  logic        mem_rd_w_o_h;
  logic        reg_write_w_o_h;
  logic        pc_write_w_o_h;
  logic        instr_done_w_o_h;
  logic        fault_w_o_h;

  modport master (
    input  opcode_w_i, mem_ready_w_i_h,
    output ctrl_w_o, state_w_o, mem_req_w_o_h, instr_sel_w_o_h, ir_write_w_o_h,
           mem_wr_w_o_h, mem_rd_w_o_h, reg_write_w_o_h, pc_write_w_o_h,
           instr_done_w_o_h, fault_w_o_h
  );

  modport slave (
    output opcode_w_i, mem_ready_w_i_h,
    input  ctrl_w_o, state_w_o, mem_req_w_o_h, instr_sel_w_o_h, ir_write_w_o_h,
           mem_wr_w_o_h, mem_rd_w_o_h, reg_write_w_o_h, pc_write_w_o_h,
           instr_done_w_o_h, fault_w_o_h
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with registered control
// word, memory wait-state handling, timeout and sticky illegal-opcode fault.
module multicycle_control #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic                 clk_w_i,
  input  logic                 rst_w_i_h,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] WAIT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  state_t           state, state_n;
  logic [10:0]      ctrl_q;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
  logic [10:0]      dec_ctrl;
  logic             dec_legal;
  logic             ready;
  logic             waiting;
  logic             timeout_hit;
  logic             last_cycle;

  assign ready       = bus.mem_ready_w_i_h;
  assign waiting     = (state == S_FETCH || state == S_MEM) && !ready;
  assign timeout_hit = TIMEOUT_EN && waiting && (wait_cnt == WAIT_LAST);

  // Control word bit order: {reg_write, mem_wr, mem_rd, branch, mem_to_reg,
  // jal, imm_to_reg, alu_src_a, alu_src_b, pc_to_reg, cmp_branch}
  always_comb begin
    dec_ctrl  = '0;
    dec_legal = 1'b1;
    case (bus.opcode_w_i)
      7'b1101111: dec_ctrl = 11'b100_1010_1110;
      7'b1100111: dec_ctrl = 11'b100_1010_1110;
      7'b0110111: dec_ctrl = 11'b100_0001_0000;
      7'b0010111: dec_ctrl = 11'b100_0000_1100;
      7'b1100011: dec_ctrl = 11'b000_1000_1101;
      7'b0100011: dec_ctrl = 11'b010_0000_0000;
      7'b0000011: dec_ctrl = 11'b101_0100_0100;
      7'b0010011: dec_ctrl = 11'b100_0000_0100;
      7'b0110011: dec_ctrl = 11'b100_0000_0000;
      default:    dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_n    = state;
    wait_cnt_n = waiting ? wait_cnt + 1'b1 : '0;
    case (state)
      S_FETCH: begin
        if (ready)            state_n = S_DECODE;
        else if (timeout_hit) state_n = S_FAULT;
      end
      S_DECODE: state_n = dec_legal ? S_EXEC : S_FAULT;
      S_EXEC: begin
        if (ctrl_q[9] || ctrl_q[8]) state_n = S_MEM;
        else if (ctrl_q[10])        state_n = S_WB;
        else                        state_n = S_FETCH;
      end
      S_MEM: begin
        if (ready)            state_n = ctrl_q[8] ? S_WB : S_FETCH;
        else if (timeout_hit) state_n = S_FAULT;
      end
      S_WB:    state_n = S_FETCH;
      S_FAULT: state_n = S_FAULT;
      default: state_n = S_FAULT;
    endcase
  end

  always_ff @(posedge clk_w_i) begin
    if (rst_w_i_h) begin
      state    <= S_FETCH;
      ctrl_q   <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      // Illegal opcodes latch an all-zero word so FAULT shows no stale control.
      if (state == S_DECODE) ctrl_q <= dec_ctrl;
    end
  end

  // Final cycle: WB, a completing store, or EXEC when nothing follows it.
  assign last_cycle = (state == S_WB) ||
                      (state == S_MEM && ready && ctrl_q[9]) ||
                      (state == S_EXEC && !(ctrl_q[10] || ctrl_q[9] || ctrl_q[8]));

  assign bus.ctrl_w_o         = ctrl_q;
  assign bus.state_w_o        = state;
  assign bus.mem_req_w_o_h    = (state == S_FETCH) || (state == S_MEM);
  assign bus.instr_sel_w_o_h  = (state == S_FETCH);
  assign bus.ir_write_w_o_h   = (state == S_FETCH) && ready;
  assign bus.mem_wr_w_o_h     = (state == S_MEM) && ctrl_q[9];
  assign bus.mem_rd_w_o_h     = (state == S_MEM) && ctrl_q[8];
  assign bus.reg_write_w_o_h  = (state == S_WB) && ctrl_q[10];
  assign bus.pc_write_w_o_h   = last_cycle;
  assign bus.instr_done_w_o_h = last_cycle;
  assign bus.fault_w_o_h      = (state == S_FAULT);

endmodule
